// File: rtl/spm_mult.sv
// -----------------------------------------------------------------------------
// spm_mult
//
// Purpose:
//   Serial-parallel multiplier built from a chain of WIDTH carry-save cells.
//   The multiplicand is held in parallel in x_reg. The multiplier is shifted
//   through the chain LSB-first from y_reg. One product bit leaves the chain
//   per cycle. The full 2*WIDTH-bit product is collected in a shift register
//   and handed out with a valid/ready handshake.
//
// Parameters:
//   WIDTH  - operand width in bits (2..64)
//   SIGNED - 1: two's-complement operands and product, 0: unsigned
//
// Ports:
//   clk       - clock, all flops rise-edge
//   rst       - asynchronous active-low reset
//   in_valid  - operand pair valid
//   in_ready  - block can accept operands (high only in IDLE)
//   a         - parallel multiplicand
//   b         - multiplier, consumed serially LSB-first
//   out_valid - product valid (high only in DONE)
//   out_ready - consumer accepts product
//   p         - 2*WIDTH-bit product, driven only from the product register
//   busy      - high in RUN or DONE
// -----------------------------------------------------------------------------
module spm_mult #(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy
);

    localparam int               CNT_W    = $clog2(2 * WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    // Operand registers.
    logic [WIDTH-1:0]   x_reg;
    logic [WIDTH-1:0]   y_reg;

    // Per-cell carry-save state: cell i owns sum_reg[i] and carry_reg[i].
    logic [WIDTH-1:0]   sum_reg;
    logic [WIDTH-1:0]   carry_reg;

    // Per-cell combinational inputs and results for the current cycle.
    logic [WIDTH-1:0]   pp;
    logic [WIDTH-1:0]   sum_in;
    logic [WIDTH-1:0]   sum_nxt;
    logic [WIDTH-1:0]   carry_nxt;

    logic [2*WIDTH-1:0] prod_reg;
    logic [CNT_W-1:0]   count;

    logic               accept;
    logic               y_fill;
    logic               top_in;

    // -------------------------------------------------------------------------
    // Control decode.
    // -------------------------------------------------------------------------
    assign accept = (state == IDLE) && in_valid;

    // Bit shifted into the top of y_reg. In signed mode the register shifts
    // arithmetically, so once all of b has been consumed the chain keeps
    // seeing b's sign bit. In unsigned mode zeros follow b.
    assign y_fill = SIGNED ? y_reg[WIDTH-1] : 1'b0;

    // Signed mode uses the Baugh-Wooley form for the negative-weight top bit
    // of x. The top cell adds ~(x[MSB] & y) instead of subtracting
    // x[MSB] & y. The constant left over from the 2*WIDTH inverted terms
    // reduces to 2^(WIDTH-1) mod 2^(2*WIDTH). That constant is injected once,
    // through the top cell's sum input on the first RUN cycle. Every value in
    // the chain then stays non-negative, and the carry-save arithmetic is
    // exact.
    assign top_in = SIGNED && (count == '0);

    // -------------------------------------------------------------------------
    // Carry-save cell chain. Each cell is a full adder. Its inputs are its
    // partial product bit, the sum from the neighbouring cell above (the
    // right shift of the accumulator), and its own carry from the previous
    // cycle. The new sum of cell 0 is the product bit produced this cycle.
    // -------------------------------------------------------------------------
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        if (i == WIDTH - 1) begin : g_top
            assign sum_in[i] = top_in;
            if (SIGNED) begin : g_signed_pp
                assign pp[i] = ~(x_reg[i] & y_reg[0]);
            end else begin : g_unsigned_pp
                assign pp[i] = x_reg[i] & y_reg[0];
            end
        end else begin : g_body
            assign sum_in[i] = sum_reg[i+1];
            assign pp[i]     = x_reg[i] & y_reg[0];
        end

        assign sum_nxt[i]   = pp[i] ^ sum_in[i] ^ carry_reg[i];
        assign carry_nxt[i] = (pp[i] & sum_in[i])
                            | (pp[i] & carry_reg[i])
                            | (sum_in[i] & carry_reg[i]);
    end

    // -------------------------------------------------------------------------
    // FSM state register.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and handshake outputs.
    // RUN lasts exactly 2*WIDTH cycles. DONE always returns to IDLE before a
    // new pair is accepted.
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (count == CNT_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers.
    // Accepting a pair captures the operands and clears the chain, the product
    // register and the counter, so nothing from an earlier or aborted
    // operation can leak into the new one. In RUN the chain advances one
    // step, y shifts right, and the bit leaving cell 0 enters the product
    // register at its MSB. After 2*WIDTH steps the product is LSB-aligned.
    // In IDLE and DONE everything holds, which keeps p stable under
    // backpressure.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_reg     <= '0;
            y_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= '0;
            prod_reg  <= '0;
            count     <= '0;
        end else if (accept) begin
            x_reg     <= a;
            y_reg     <= b;
            sum_reg   <= '0;
            carry_reg <= '0;
            prod_reg  <= '0;
            count     <= '0;
        end else if (state == RUN) begin
            y_reg     <= {y_fill, y_reg[WIDTH-1:1]};
            sum_reg   <= sum_nxt;
            carry_reg <= carry_nxt;
            prod_reg  <= {sum_nxt[0], prod_reg[2*WIDTH-1:1]};
            if (count == CNT_LAST) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    assign p = prod_reg;

endmodule
